// File: rtl/score_keeper_pkg.sv
// Shared types and constants for the score keeper and its serve timer.
package score_keeper_pkg;

  localparam int unsigned SCORE_W          = 3;
  localparam int unsigned SERVE_CNT_W      = 8;
  localparam int unsigned DEF_WIN_SCORE    = 7;
  localparam int unsigned DEF_SERVE_FRAMES = 60;

  typedef enum logic [1:0] {
    SK_SERVE     = 2'd0,
    SK_PLAY      = 2'd1,
    SK_GAME_OVER = 2'd2
  } sk_state_e;

  // Score increment that sticks at the top of the 3-bit range
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == {SCORE_W{1'b1}}) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/score_keeper_serve_timer.sv
// Frame-tick down-counter that holds the ball for SERVE_FRAMES ticks and
// flags the tick on which the serve delay runs out.
module score_keeper_serve_timer
  import score_keeper_pkg::*;
#(
  parameter int unsigned SERVE_FRAMES = DEF_SERVE_FRAMES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic tick,
  input  logic reload,
  output logic expire_c
);

  localparam logic [SERVE_CNT_W-1:0] RELOAD_VAL = SERVE_CNT_W'(SERVE_FRAMES - 1);

  logic [SERVE_CNT_W-1:0] cnt_q, cnt_d;

  // Reload wins over a same-cycle tick so that tick never counts toward the new delay
  always_comb begin
    cnt_d    = cnt_q;
    expire_c = 1'b0;
    if (reload) begin
      cnt_d = RELOAD_VAL;
    end else if (en && tick) begin
      if (cnt_q == '0) begin
        expire_c = 1'b1;
      end else begin
        cnt_d = cnt_q - SERVE_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RELOAD_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Pong score keeper: serve delay, point awarding and game-over sequencing.
// Optional SCORE_MISS_EDGE_EN turns the miss inputs into registered rising edges.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = DEF_WIN_SCORE,
  parameter int unsigned SERVE_FRAMES = DEF_SERVE_FRAMES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               miss_left,
  input  logic               miss_right,
  input  logic               restart,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic               serve_hold,
  output logic               serve_dir,
  output logic               game_over,
  output logic               winner
);

  localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

  sk_state_e          state_q, state_d;
  logic [SCORE_W-1:0] score_left_q, score_left_d;
  logic [SCORE_W-1:0] score_right_q, score_right_d;
  logic               serve_hold_q, serve_hold_d;
  logic               serve_dir_q, serve_dir_d;
  logic               game_over_q, game_over_d;
  logic               winner_q, winner_d;
  logic               reload_c;
  logic               expire_c;
  logic               miss_l_c, miss_r_c;
  logic [SCORE_W-1:0] inc_left_c, inc_right_c;

`ifdef SCORE_MISS_EDGE_EN
  logic miss_l_prev_q, miss_r_prev_q, miss_l_ev_q, miss_r_ev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_l_prev_q <= 1'b0;
      miss_r_prev_q <= 1'b0;
      miss_l_ev_q   <= 1'b0;
      miss_r_ev_q   <= 1'b0;
    end else begin
      miss_l_prev_q <= miss_left;
      miss_r_prev_q <= miss_right;
      miss_l_ev_q   <= miss_left & ~miss_l_prev_q;
      miss_r_ev_q   <= miss_right & ~miss_r_prev_q;
    end
  end

  assign miss_l_c = miss_l_ev_q;
  assign miss_r_c = miss_r_ev_q;
`else
  assign miss_l_c = miss_left;
  assign miss_r_c = miss_right;
`endif

  assign inc_left_c  = sat_inc(score_left_q);
  assign inc_right_c = sat_inc(score_right_q);

  score_keeper_serve_timer #(
    .SERVE_FRAMES(SERVE_FRAMES)
  ) u_serve_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state_q == SK_SERVE),
    .tick    (frame_tick),
    .reload  (reload_c),
    .expire_c(expire_c)
  );

  always_comb begin
    state_d       = state_q;
    score_left_d  = score_left_q;
    score_right_d = score_right_q;
    serve_dir_d   = serve_dir_q;
    game_over_d   = game_over_q;
    winner_d      = winner_q;
    reload_c      = 1'b0;

    if (restart) begin
      state_d       = SK_SERVE;
      score_left_d  = '0;
      score_right_d = '0;
      serve_dir_d   = 1'b0;
      game_over_d   = 1'b0;
      winner_d      = 1'b0;
      reload_c      = 1'b1;
    end else begin
      unique case (state_q)
        SK_SERVE: begin
          if (expire_c) state_d = SK_PLAY;
        end
        SK_PLAY: begin
          if (miss_l_c && miss_r_c) begin
            state_d  = SK_SERVE;
            reload_c = 1'b1;
          end else if (miss_r_c) begin
            score_left_d = inc_left_c;
            serve_dir_d  = 1'b1;
            if (inc_left_c == WIN_VAL) begin
              state_d     = SK_GAME_OVER;
              game_over_d = 1'b1;
              winner_d    = 1'b0;
            end else begin
              state_d  = SK_SERVE;
              reload_c = 1'b1;
            end
          end else if (miss_l_c) begin
            score_right_d = inc_right_c;
            serve_dir_d   = 1'b0;
            if (inc_right_c == WIN_VAL) begin
              state_d     = SK_GAME_OVER;
              game_over_d = 1'b1;
              winner_d    = 1'b1;
            end else begin
              state_d  = SK_SERVE;
              reload_c = 1'b1;
            end
          end
        end
        SK_GAME_OVER: begin
          state_d = SK_GAME_OVER;
        end
        default: begin
          state_d  = SK_SERVE;
          reload_c = 1'b1;
        end
      endcase
    end

    serve_hold_d = (state_d != SK_PLAY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SK_SERVE;
      score_left_q  <= '0;
      score_right_q <= '0;
      serve_hold_q  <= 1'b1;
      serve_dir_q   <= 1'b0;
      game_over_q   <= 1'b0;
      winner_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      score_left_q  <= score_left_d;
      score_right_q <= score_right_d;
      serve_hold_q  <= serve_hold_d;
      serve_dir_q   <= serve_dir_d;
      game_over_q   <= game_over_d;
      winner_q      <= winner_d;
    end
  end

  assign score_left  = score_left_q;
  assign score_right = score_right_q;
  assign serve_hold  = serve_hold_q;
  assign serve_dir   = serve_dir_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;

endmodule
